// File: rtl/stream_arb_pkg.sv
// Shared constants, FSM encoding and width helper for the stream share arbiter.
package stream_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so single-entry ranges still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_share_arbiter_if.sv
// Requester, processor and response stream bundle for the stream share arbiter.
interface stream_share_arbiter_if
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;

    logic                           pa_valid;
    logic [DATA_W-1:0]              pa_data;
    logic                           pa_ready;

    logic                           pb_valid;
    logic [DATA_W-1:0]              pb_data;
    logic                           pb_ready;

    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] rsp_data;
    logic [NUM_REQ-1:0]             rsp_ready;

    // master: requesters + processor + response sinks; slave: the arbiter
    modport master (
        output req_valid, req_data, req_last, pa_ready, pb_valid, pb_data, rsp_ready,
        input  req_ready, pa_valid, pa_data, pb_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_last, pa_ready, pb_valid, pb_data, rsp_ready,
        output req_ready, pa_valid, pa_data, pb_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/stream_arb_tag_fifo.sv
// In-order owner-tag FIFO; a push while full is taken only alongside a pop.
module stream_arb_tag_fifo
    import stream_arb_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/stream_share_arbiter.sv
// Round-robin burst sharing of one in-order stream processor among NUM_REQ requesters.
// Optional STREAM_SHARE_ARB_STATS_EN adds per-requester word and stall counters.
module stream_share_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int BURST_LEN = 16,
    parameter int TAG_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    stream_share_arbiter_if.slave bus,
    output logic                  busy,
    output logic                  tag_err
`ifdef STREAM_SHARE_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][DATA_W-1:0] stat_words,
    output logic [DATA_W-1:0]              stat_stall
`endif
);
    localparam int IDW = clog2(NUM_REQ);
    localparam int BCW = clog2(BURST_LEN);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [BCW-1:0] beat_q, beat_d;
    logic           tag_err_q;

    logic           found;
    logic [IDW-1:0] pick;
    logic           xfer, pa_valid_w, accept, last_beat;
    logic           tag_full, tag_empty, tag_pop;
    logic [IDW-1:0] head;

    assign xfer       = (state_q == XFER);
    assign pa_valid_w = xfer && bus.req_valid[grant_q] && !tag_full;
    assign accept     = pa_valid_w && bus.pa_ready;
    assign last_beat  = bus.req_last[grant_q] || (beat_q == BCW'(BURST_LEN - 1));
    assign tag_pop    = bus.pb_valid && bus.pb_ready;
    assign tag_err    = tag_err_q;

    // First valid requester at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IDW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB;
            grant_q   <= '0;
            rr_q      <= '0;
            beat_q    <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            if (bus.pb_valid && tag_empty) tag_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        case (state_q)
            ARB: begin
                if (found) begin
                    grant_d = pick;
                    beat_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = ARB;
                        rr_d    = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Steering is purely combinational from registered grant and tag head.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.pa_valid  = pa_valid_w;
        bus.pa_data   = bus.req_data[grant_q];
        if (xfer) bus.req_ready[grant_q] = bus.pa_ready && !tag_full;
        bus.pb_ready  = !tag_empty && bus.rsp_ready[head];
        if (!tag_empty) bus.rsp_valid[head] = bus.pb_valid;
        for (int i = 0; i < NUM_REQ; i++) bus.rsp_data[i] = bus.pb_data;
        busy = xfer || !tag_empty;
    end

    stream_arb_tag_fifo #(
        .W     (IDW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (accept),
        .din_i   (grant_q),
        .pop_i   (tag_pop),
        .dout_o  (head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

`ifdef STREAM_SHARE_ARB_STATS_EN
    logic [NUM_REQ-1:0][DATA_W-1:0] words_q;
    logic [DATA_W-1:0]              stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            if (accept) words_q[grant_q] <= words_q[grant_q] + 1'b1;
            if (pa_valid_w && !bus.pa_ready) stall_q <= stall_q + 1'b1;
        end
    end

    assign stat_words = words_q;
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_stream_share_arbiter.sv
// Randomized bench for stream_share_arbiter with a processor model and a grant-order model.
module tb_stream_share_arbiter;
    import stream_arb_pkg::*;

    localparam int NR   = 2;
    localparam int BL   = 16;
    localparam int TD   = 8;
    localparam int PCAP = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy, tag_err;
    always #5 clk = ~clk;

    stream_share_arbiter_if #(.NUM_REQ(NR)) bus();

`ifdef STREAM_SHARE_ARB_STATS_EN
    logic [NR-1:0][31:0] stat_words;
    logic [31:0]         stat_stall;
`endif

    stream_share_arbiter #(
        .NUM_REQ   (NR),
        .BURST_LEN (BL),
        .TAG_DEPTH (TD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .tag_err (tag_err)
`ifdef STREAM_SHARE_ARB_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] src_q [NR][$];
    bit          src_last [NR][$];
    logic [31:0] exp_q [NR][$];
    logic [31:0] pipe [$];
    int          acc_ids [$];
    int          acc_cyc [$];
    int          mdl_ids [$];
    int          rcv [NR];
    bit          en [NR];
    bit          hold [NR];
    bit          rsp_rand, pa_rand, force_pb;
    int          coef;

    // Processor transfer function: identity in bypass, else x*5*5243>>21.
    function automatic logic [31:0] xf(input logic [31:0] x);
        logic [63:0] p;
        p = 64'(x) * 64'd5 * 64'd5243;
        return (coef == 0) ? x : 32'(p >> 21);
    endfunction

    task automatic clear_tb();
        for (int i = 0; i < NR; i++) begin
            src_q[i].delete(); src_last[i].delete(); exp_q[i].delete();
            rcv[i] = 0; en[i] = 0; hold[i] = 0;
        end
        pipe.delete(); acc_ids.delete(); acc_cyc.delete(); mdl_ids.delete();
        rsp_rand = 0; pa_rand = 0; force_pb = 0; coef = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i] = en[i] && (src_q[i].size() > 0);
            bus.req_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : 32'h0;
            bus.req_last[i]  = (src_q[i].size() > 0) ? src_last[i][0] : 1'b0;
            bus.rsp_ready[i] = !hold[i] && (!rsp_rand || $urandom_range(0, 1) == 1);
        end
        bus.pb_valid = force_pb || (pipe.size() > 0);
        bus.pb_data  = (pipe.size() > 0) ? pipe[0] : 32'hdead_beef;
        bus.pa_ready = (pipe.size() < PCAP) && (!pa_rand || $urandom_range(0, 3) != 0);
    endtask

    task automatic add_stream(input int r, input int n, input bit last_at_end);
        for (int k = 0; k < n; k++) begin
            src_q[r].push_back($urandom);
            src_last[r].push_back(last_at_end && (k == n - 1));
        end
    endtask

    // Grant order from the rules: round robin from the pointer, burst ends on
    // last or BL words; a requester running dry without last keeps the grant.
    task automatic build_model();
        int pos [NR];
        int ptr, sel, n;
        bit l, stop;
        for (int i = 0; i < NR; i++) pos[i] = 0;
        mdl_ids.delete();
        ptr = 0; stop = 0;
        while (!stop) begin
            sel = -1;
            for (int k = 0; k < NR; k++)
                if (sel < 0 && pos[(ptr + k) % NR] < src_last[(ptr + k) % NR].size())
                    sel = (ptr + k) % NR;
            if (sel < 0) break;
            n = 0; l = 0;
            while (pos[sel] < src_last[sel].size() && n < BL) begin
                l = src_last[sel][pos[sel]];
                pos[sel]++; n++;
                mdl_ids.push_back(sel);
                if (l) break;
            end
            if (!l && n < BL) stop = 1;
            ptr = (sel + 1) % NR;
        end
    endtask

    task automatic step();
        bit acc [NR];
        bit pa_acc, pb_acc;
        logic [31:0] pa_d;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NR; i++) acc[i] = bus.req_valid[i] && bus.req_ready[i];
        pa_acc = bus.pa_valid && bus.pa_ready;
        pa_d   = bus.pa_data;
        pb_acc = bus.pb_valid && bus.pb_ready;
        for (int i = 0; i < NR; i++) begin
            if (bus.rsp_valid[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_spurious lane %0d: valid with data %h, required no response", i, bus.rsp_data[i]);
                end else if (bus.rsp_ready[i]) begin
                    tests++;
                    if (bus.rsp_data[i] !== exp_q[i][0]) begin
                        fails++;
                        $display("FAIL rsp_data lane %0d: got %h, required %h", i, bus.rsp_data[i], exp_q[i][0]);
                    end
                    void'(exp_q[i].pop_front());
                    rcv[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (reset_n) begin
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    exp_q[i].push_back(xf(src_q[i][0]));
                    void'(src_q[i].pop_front());
                    void'(src_last[i].pop_front());
                    acc_ids.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            if (pa_acc) pipe.push_back(xf(pa_d));
            if (pb_acc) void'(pipe.pop_front());
        end
        drive_inputs();
    endtask

    task automatic run_until_drained(input string name, input int budget);
        int k;
        bit done;
        done = 0;
        for (k = 0; k < budget && !done; k++) begin
            step();
            done = (pipe.size() == 0);
            for (int i = 0; i < NR; i++)
                if (src_q[i].size() != 0 || exp_q[i].size() != 0) done = 0;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_timeout: not drained after %0d cycles, required drained", name, budget);
        end
    endtask

    task automatic check_seq(input string name);
        int bad;
        tests++;
        if (acc_ids.size() !== mdl_ids.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d accepted words, required %0d", name, acc_ids.size(), mdl_ids.size());
        end
        bad = -1;
        for (int k = 0; k < acc_ids.size() && k < mdl_ids.size(); k++)
            if (bad < 0 && acc_ids[k] != mdl_ids[k]) bad = k;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s_order: word %0d from requester %0d, required %0d", name, bad, acc_ids[bad], mdl_ids[bad]);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_tb();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b, required 00", bus.req_ready); end
        tests++; if (bus.pa_valid !== 1'b0) begin fails++; $display("FAIL reset_pa_valid: got %b, required 0", bus.pa_valid); end
        tests++; if (bus.pb_ready !== 1'b0) begin fails++; $display("FAIL reset_pb_ready: got %b, required 0", bus.pb_ready); end
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b, required 00", bus.rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL reset_tag_err: got %b, required 0", tag_err); end
    endtask

    task automatic test_single_burst();
        int g0, g1, g2;
        do_reset();
        add_stream(0, 20, 1'b0);
        build_model();
        en[0] = 1;
        drive_inputs();
        run_until_drained("single", 200);
        check_seq("single");
        g0 = -1; g1 = -1; g2 = -1;
        if (acc_cyc.size() >= 20) begin
            g0 = acc_cyc[15] - acc_cyc[0];
            g1 = acc_cyc[16] - acc_cyc[15];
            g2 = acc_cyc[19] - acc_cyc[16];
        end
        tests++; if (g0 != 15) begin fails++; $display("FAIL single_burst_span: got %0d, required 15", g0); end
        tests++; if (g1 != 2) begin fails++; $display("FAIL single_arb_gap: got %0d, required 2", g1); end
        tests++; if (g2 != 3) begin fails++; $display("FAIL single_tail_span: got %0d, required 3", g2); end
        tests++; if (rcv[0] != 20) begin fails++; $display("FAIL single_rcv0: got %0d, required 20", rcv[0]); end
        tests++; if (rcv[1] != 0) begin fails++; $display("FAIL single_rcv1: got %0d, required 0", rcv[1]); end
    endtask

    task automatic test_alternate();
        do_reset();
        coef = 5;
        add_stream(0, 40, 1'b1);
        add_stream(1, 40, 1'b1);
        build_model();
        en[0] = 1; en[1] = 1;
        drive_inputs();
        run_until_drained("alt", 400);
        check_seq("alt");
        tests++; if (rcv[0] != 40 || rcv[1] != 40) begin
            fails++; $display("FAIL alt_rcv: got %0d/%0d, required 40/40", rcv[0], rcv[1]);
        end
    endtask

    task automatic test_last();
        do_reset();
        pa_rand = 1;
        add_stream(0, 1, 1'b1); add_stream(0, 5, 1'b1);
        add_stream(1, 3, 1'b1); add_stream(1, 4, 1'b1);
        build_model();
        en[0] = 1; en[1] = 1;
        drive_inputs();
        run_until_drained("last", 300);
        check_seq("last");
    endtask

    task automatic test_backpressure();
        do_reset();
        add_stream(0, 30, 1'b1);
        build_model();
        en[0] = 1; hold[0] = 1;
        drive_inputs();
        repeat (50) step();
        tests++; if (acc_ids.size() != TD) begin fails++; $display("FAIL bp_fill: got %0d accepted, required %0d", acc_ids.size(), TD); end
        tests++; if (bus.req_ready[0] !== 1'b0) begin fails++; $display("FAIL bp_req_ready: got %b, required 0", bus.req_ready[0]); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b, required 1", busy); end
        hold[0] = 0; rsp_rand = 1;
        run_until_drained("bp", 600);
        check_seq("bp");
        tests++; if (rcv[0] != 30) begin fails++; $display("FAIL bp_rcv: got %0d, required 30", rcv[0]); end
    endtask

    task automatic test_tag_err();
        do_reset();
        force_pb = 1;
        drive_inputs();
        #1;
        tests++; if (bus.pb_ready !== 1'b0) begin fails++; $display("FAIL err_pb_ready: got %b, required 0", bus.pb_ready); end
        tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL err_early: got %b, required 0", tag_err); end
        step();
        force_pb = 0;
        drive_inputs();
        tests++; if (tag_err !== 1'b1) begin fails++; $display("FAIL err_set: got %b, required 1", tag_err); end
        repeat (5) step();
        tests++; if (tag_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b, required 1", tag_err); end
        do_reset();
        tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b, required 0", tag_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_stream(0, 1, 1'b1);
        add_stream(1, 20, 1'b1);
        en[0] = 1; en[1] = 1;
        drive_inputs();
        repeat (8) step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b, required 1", busy); end
        reset_n = 1'b0;
        #1;
        tests++; if (bus.req_ready !== 2'b00 || bus.pa_valid !== 1'b0) begin
            fails++; $display("FAIL mid_rst_in: got req_ready %b pa_valid %b, required 00 0", bus.req_ready, bus.pa_valid);
        end
        tests++; if (bus.rsp_valid !== 2'b00 || bus.pb_ready !== 1'b0 || busy !== 1'b0 || tag_err !== 1'b0) begin
            fails++; $display("FAIL mid_rst_out: got rsp_valid %b pb_ready %b busy %b tag_err %b, required 00 0 0 0",
                              bus.rsp_valid, bus.pb_ready, busy, tag_err);
        end
        clear_tb();
        add_stream(0, 4, 1'b1);
        add_stream(1, 4, 1'b1);
        build_model();
        en[0] = 1; en[1] = 1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        tests++; if (bus.pa_valid !== 1'b0) begin fails++; $display("FAIL mid_arb_first: got pa_valid %b, required 0", bus.pa_valid); end
        run_until_drained("mid", 200);
        check_seq("mid");
    endtask

    task automatic test_random();
        int tot [NR];
        do_reset();
        coef = 5; pa_rand = 1; rsp_rand = 1;
        for (int r = 0; r < NR; r++) begin
            tot[r] = 0;
            for (int c = 0; c < 4; c++) begin
                int n;
                n = $urandom_range(1, 24);
                tot[r] += n;
                add_stream(r, n, (c == 3) || ($urandom_range(0, 1) == 1));
            end
        end
        build_model();
        en[0] = 1; en[1] = 1;
        drive_inputs();
        run_until_drained("rand", 3000);
        check_seq("rand");
        tests++; if (rcv[0] != tot[0] || rcv[1] != tot[1]) begin
            fails++; $display("FAIL rand_rcv: got %0d/%0d, required %0d/%0d", rcv[0], rcv[1], tot[0], tot[1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_alternate();
        test_last();
        test_backpressure();
        test_tag_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_share_arbiter.md
Name: stream_share_arbiter

Overview:
- Shares one stream_processor datapath (32-bit Avalon-ST in/out) between NUM_REQ independent requesters, such as several DMA read/write channel pairs.
- Grants the processor input to one requester at a time, for a burst of words, using round-robin order.
- Records the owner of every accepted word in an in-order tag FIFO. This works because the processor pipeline preserves order with fixed per-word mapping.
- Steers each processor output word back to the response port of the requester that issued it.

Parameters:
- NUM_REQ, 2, number of requesters (2..4); ID width IDW = clog2(NUM_REQ), minimum 1.
- BURST_LEN, 16, maximum words forwarded per grant before re-arbitration (1..256).
- TAG_DEPTH, 8, tag FIFO entries, power of 2, ≥4. Bounds words in flight inside the processor.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester Avalon-ST sink valid
- req_data  in  32*NUM_REQ  per-requester data; requester i occupies [32*i+31:32*i]
- req_last  in  NUM_REQ  marks the final word of the requester's burst; ends the grant early
- req_ready  out  NUM_REQ  per-requester ready
- pa_valid  out  1  to processor asi_valid
- pa_data  out  32  to processor asi_data
- pa_ready  in  1  from processor asi_ready
- pb_valid  in  1  from processor aso_valid
- pb_data  in  32  from processor aso_data
- pb_ready  out  1  to processor aso_ready
- rsp_valid  out  NUM_REQ  per-requester response valid
- rsp_data  out  32*NUM_REQ  per-requester response data; pb_data replicated to every lane
- rsp_ready  in  NUM_REQ  per-requester response ready
- busy  out  1  high when in XFER or when the tag FIFO is non-empty
- tag_err  out  1  sticky; set when pb_valid=1 while the tag FIFO is empty

Behaviour:
Reset values:
- FSM in ARB; rr_ptr=0; grant_id=0; beat_cnt=0; tag FIFO empty.
- All req_ready, pa_valid, pb_ready, rsp_valid, busy and tag_err are 0.

FSM ARB:
- Search requesters starting at rr_ptr for the first with req_valid=1, wrapping modulo NUM_REQ.
- If one is found: grant_id <= i, beat_cnt <= 0, go to XFER the next cycle. No data moves in ARB.
- If none is found: stay in ARB.

FSM XFER (combinational forwarding from the granted requester):
- pa_valid = req_valid[grant_id] AND !tag_full.
- pa_data = req_data[grant_id].
- req_ready[grant_id] = pa_ready AND !tag_full; all other req_ready = 0.
- Accept occurs when pa_valid AND pa_ready. On accept: push grant_id into the tag FIFO and increment beat_cnt.
- Leave XFER to ARB on an accept where req_last=1 or beat_cnt==BURST_LEN-1. At that point rr_ptr <= grant_id+1, wrapping modulo NUM_REQ.
- An idle gap (req_valid low) does not end the grant.

Return path (active in every state):
- head = tag FIFO output.
- rsp_valid[head] = pb_valid AND !tag_empty; all other rsp_valid = 0.
- pb_ready = !tag_empty AND rsp_ready[head].
- Pop the tag FIFO on pb_valid AND pb_ready.

Tag FIFO:
- Push and pop in the same cycle keep the count unchanged; a push is allowed when full only if a pop occurs that same cycle.
- When full, pa_valid and req_ready are forced low. This is the only input-side stall besides pa_ready.
- Pointers wrap at TAG_DEPTH with an extra wrap bit for the full/empty distinction.

tag_err:
- When pb_valid=1 and the FIFO is empty: pb_ready=0 and tag_err <= 1.
- tag_err is cleared only by reset.

Latency:
- Grant to first forward: 1 cycle (the ARB cycle).
- No added latency on the data path in either direction; all steering is combinational from registered state.

Reset asserted mid-burst:
- Everything returns to reset values immediately.
- Words in flight inside the processor must be flushed by resetting the processor together with this block.

Optional Feature:
- Macro: STREAM_SHARE_ARB_STATS_EN.
- When defined:
  - Adds output port stat_words (32*NUM_REQ), holding per-requester counts of accepted input words.
  - Adds output port stat_stall (32), counting cycles where pa_valid=1 and pa_ready=0.
  - All counters reset to 0 and wrap at 2^32.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package stream_arb_pkg holds:
  - localparams DATA_W=32 and the FSM state encoding (ARB=1'b0, XFER=1'b1);
  - the function clog2 used to derive IDW.
- One natural sub-module: stream_arb_tag_fifo, a synchronous FIFO of width IDW and depth TAG_DEPTH with full/empty flags and a same-cycle push/pop rule.

Test Plan:
- Req0 only, 20 words, no req_last, BURST_LEN=16, processor in bypass: 16 words forwarded, then 1 ARB cycle, then 4 words. All 20 return on rsp0 in order; rsp_valid[1] stays 0.
- Both requesters valid continuously, 40 words each: grants alternate 0,1,0,1 in 16-word bursts. Each rsp lane receives exactly its own 40 words in order, checked against processor coefficient 5 (output = in*5*5243>>21, e.g. in=100 → 1).
- req_last on word 3 of req1 while req0 waits: req1 burst length is 3, then req0 is granted next; rr_ptr moves to 0.
- rsp_ready[0]=0 for 50 cycles with req0 streaming: tag FIFO fills to 8 and req_ready[0] drops. After release, all words are delivered with none lost or duplicated.
- pb_valid forced high with the FIFO empty: tag_err=1 the next cycle, pb_ready=0, and tag_err stays 1 until reset.
- reset_n pulsed low mid-burst: all outputs return to 0 within the reset and the FSM is in ARB. The first grant after reset goes to req0.
